// File: rtl/simv_run_pkg.sv
// Shared types and constants for the simulation run sequencer.
// Optional log window feature: SIMV_RUN_CTRL_LOG_WINDOW_EN.
package simv_run_pkg;

    localparam int CODE_W_DEF = 8;
    localparam logic [7:0] TIMEOUT_CODE = 8'hFF;

    typedef enum logic [2:0] {
        HOLD,
        INIT,
        RUN,
        DRAIN,
        DONE
    } run_state_t;

endpackage

// File: rtl/simv_uart_fifo.sv
// UART character buffer between the DUT and the host shim.
// Head is read straight from storage, so it holds while unpopped.
module simv_uart_fifo
    import simv_run_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_ch,
    input  logic       pop_ready,
    output logic       out_valid,
    output logic [7:0] out_ch,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic full;
    logic pop;
    logic accept;

    assign empty = (wr_ptr == rd_ptr);
    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign out_ch = mem[rd_ptr[AW-1:0]];
    assign pop = out_valid && pop_ready;
    // A pop in the same cycle frees the slot a full-push needs.
    assign accept = push && (!full || pop);

    // Pointer advance and sticky drop flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !accept) overflow <= 1'b1;
        end
    end

    // Character storage; contents are don't-care while empty.
    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= push_ch;
    end

endmodule

// File: rtl/simv_run_ctrl.sv
// Run sequencer: DUT reset hold, init handshake, stepping, drain.
// Optional log window enabled by defining SIMV_RUN_CTRL_LOG_WINDOW_EN.
module simv_run_ctrl
    import simv_run_pkg::*;
#(
    parameter int RESET_CYCLES = 50,
    parameter int UART_DEPTH = 16,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       max_cycles,
    output logic              dut_reset,
    output logic              init_req,
    input  logic              init_ack,
    output logic              step_req,
    input  logic              step_rsp_valid,
    input  logic [CODE_W-1:0] step_rsp_code,
    input  logic              uart_in_valid,
    input  logic [7:0]        uart_in_ch,
    output logic              uart_out_valid,
    output logic [7:0]        uart_out_ch,
    input  logic              uart_out_ready,
    output logic              uart_overflow,
    output logic [63:0]       cycle_cnt,
    output logic              finish,
    output logic [CODE_W-1:0] finish_code,
    output logic              log_enable
`ifdef SIMV_RUN_CTRL_LOG_WINDOW_EN
    ,
    input  logic [63:0]       log_begin,
    input  logic [63:0]       log_end
`endif
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    run_state_t state_q;
    run_state_t state_d;
    logic [HW-1:0] hold_cnt;
    logic [31:0] max_q;
    logic hold_done;
    logic stop_step;
    logic stop_limit;
    logic fifo_empty;

    assign hold_done = (hold_cnt == HW'(RESET_CYCLES - 1));
    assign dut_reset = (state_q == HOLD);
    assign init_req = (state_q == INIT);
    assign step_req = (state_q == RUN);
    assign finish = (state_q == DONE);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= HOLD;
        else state_q <= state_d;
    end

    // Next state; a step stop and the cycle limit both end RUN.
    always_comb begin
        state_d = state_q;
        stop_step = step_rsp_valid && (step_rsp_code != '0);
        stop_limit = (max_q != '0) &&
                     ({32'd0, max_q} == cycle_cnt + 64'd1);
        unique case (state_q)
            HOLD:    if (hold_done) state_d = INIT;
            INIT:    if (init_ack) state_d = RUN;
            RUN:     if (stop_step || stop_limit) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = HOLD;
        endcase
    end

    // Hold counter, limit capture, cycle count and stop cause.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            max_q <= '0;
            cycle_cnt <= '0;
            finish_code <= '0;
        end else begin
            if (state_q == HOLD && !hold_done) hold_cnt <= hold_cnt + 1'b1;
            if (state_q == INIT && init_ack) max_q <= max_cycles;
            if (state_q == RUN) begin
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 64'd1;
                if (stop_step) finish_code <= step_rsp_code;
                else if (stop_limit) finish_code <= CODE_W'(TIMEOUT_CODE);
            end
        end
    end

`ifdef SIMV_RUN_CTRL_LOG_WINDOW_EN
    logic in_window;

    // Window test on the current count; log_end of zero never closes.
    always_comb begin
        in_window = (state_q == RUN || state_q == DRAIN) &&
                    (cycle_cnt >= log_begin) &&
                    (log_end == '0 || cycle_cnt < log_end);
    end

    // Registered window flag, one cycle behind the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) log_enable <= 1'b0;
        else log_enable <= in_window;
    end
`else
    assign log_enable = 1'b0;
`endif

    simv_uart_fifo #(
        .DEPTH(UART_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(uart_in_valid && !dut_reset),
        .push_ch(uart_in_ch),
        .pop_ready(uart_out_ready),
        .out_valid(uart_out_valid),
        .out_ch(uart_out_ch),
        .empty(fifo_empty),
        .overflow(uart_overflow)
    );

endmodule

// File: tb/tb_simv_run_ctrl.sv
// Self-checking bench for simv_run_ctrl.
// Queue-based UART model and arithmetic run-length expectations.
module tb_simv_run_ctrl;

    localparam int RC = 50;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [31:0] max_cycles = '0;
    logic dut_reset;
    logic init_req;
    logic init_ack = 1'b0;
    logic step_req;
    logic step_rsp_valid = 1'b0;
    logic [7:0] step_rsp_code = '0;
    logic uart_in_valid = 1'b0;
    logic [7:0] uart_in_ch = '0;
    logic uart_out_valid;
    logic [7:0] uart_out_ch;
    logic uart_out_ready = 1'b0;
    logic uart_overflow;
    logic [63:0] cycle_cnt;
    logic finish;
    logic [7:0] finish_code;
    logic log_enable;
`ifdef SIMV_RUN_CTRL_LOG_WINDOW_EN
    logic [63:0] log_begin = '0;
    logic [63:0] log_end = '0;
`endif

    always #5 clock = ~clock;

    simv_run_ctrl #(
        .RESET_CYCLES(RC),
        .UART_DEPTH(DEPTH),
        .CODE_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .max_cycles(max_cycles),
        .dut_reset(dut_reset),
        .init_req(init_req),
        .init_ack(init_ack),
        .step_req(step_req),
        .step_rsp_valid(step_rsp_valid),
        .step_rsp_code(step_rsp_code),
        .uart_in_valid(uart_in_valid),
        .uart_in_ch(uart_in_ch),
        .uart_out_valid(uart_out_valid),
        .uart_out_ch(uart_out_ch),
        .uart_out_ready(uart_out_ready),
        .uart_overflow(uart_overflow),
        .cycle_cnt(cycle_cnt),
        .finish(finish),
        .finish_code(finish_code),
        .log_enable(log_enable)
`ifdef SIMV_RUN_CTRL_LOG_WINDOW_EN
        ,
        .log_begin(log_begin),
        .log_end(log_end)
`endif
    );

    int nerr = 0;
    int nchk = 0;
    int t;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit exp_ovf;
    int vbad;
    int hbad;
    int nsteps;
    int fall_t;
    int init_t;
    int first_t;
    logic [63:0] first_cnt;
    bit fin_ok;

    // One clock of the UART model; inputs were set by the caller.
    task automatic step();
        int pre;
        bit pp;
        logic [7:0] tmp;
        pre = mq.size();
        if (uart_out_valid !== (pre != 0)) vbad++;
        if (uart_out_valid === 1'b1 && pre != 0 && uart_out_ch !== mq[0])
            hbad++;
        if (uart_out_valid === 1'b1 && uart_out_ready)
            got_q.push_back(uart_out_ch);
        if (step_req === 1'b1) nsteps++;
        pp = uart_out_ready && pre != 0;
        if (pp) tmp = mq.pop_front();
        if (uart_in_valid && t >= RC) begin
            if (pre < DEPTH || pp) begin
                mq.push_back(uart_in_ch);
                exp_q.push_back(uart_in_ch);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(negedge clock);
        t++;
    endtask

    task automatic clear_model();
        mq.delete();
        exp_q.delete();
        got_q.delete();
        exp_ovf = 1'b0;
        vbad = 0;
        hbad = 0;
        nsteps = 0;
        t = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        init_ack = 1'b0;
        step_rsp_valid = 1'b0;
        step_rsp_code = '0;
        uart_in_valid = 1'b0;
        uart_out_ready = 1'b0;
        max_cycles = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clear_model();
    endtask

    // Reset, then handshake into RUN with an unlimited run.
    task automatic bring_up(input int ack_dly);
        do_reset();
        for (int n = 0; n < 200 && init_req !== 1'b1; n++) step();
        repeat (ack_dly) step();
        init_ack = 1'b1;
        step();
        init_ack = 1'b0;
    endtask

    // Full randomized run from reset to finish.
    task automatic run_case(input int m, input int s, input logic [7:0] sc,
                            input int ack_dly, input int p_uart,
                            input int p_rdy, input int hold, input int e);
        int k;
        int hold_n;
        k = 0;
        hold_n = 0;
        do_reset();
        max_cycles = m;
        fall_t = -1;
        init_t = -1;
        first_t = -1;
        first_cnt = '1;
        fin_ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (dut_reset === 1'b0 && fall_t < 0) fall_t = t;
            if (init_req === 1'b1 && init_t < 0) init_t = t;
            if (step_req === 1'b1 && first_t < 0) begin
                first_t = t;
                first_cnt = cycle_cnt;
            end
            if (finish === 1'b1) begin
                fin_ok = 1'b1;
                break;
            end
            init_ack = (init_t >= 0 && t == init_t + ack_dly);
            if (step_req === 1'b1) begin
                k++;
                step_rsp_valid = (k == s) ? 1'b1 : 1'($urandom % 2);
                step_rsp_code = (k == s) ? sc : 8'h00;
            end else begin
                step_rsp_valid = 1'($urandom % 2);
                step_rsp_code = 8'($urandom);
            end
            uart_in_valid = ($urandom_range(99) < p_uart);
            uart_in_ch = 8'($urandom);
            if (k >= e && hold_n < hold) begin
                uart_out_ready = 1'b0;
                hold_n++;
            end else begin
                uart_out_ready = ($urandom_range(99) < p_rdy);
            end
            step();
        end
        init_ack = 1'b0;
        step_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        nchk++;
        if ({dut_reset, init_req, step_req, uart_out_valid, uart_overflow,
             finish, log_enable} !== 7'b1000000) begin
            nerr++;
            $display("FAIL reset_flags got=%b want=1000000",
                     {dut_reset, init_req, step_req, uart_out_valid,
                      uart_overflow, finish, log_enable});
        end
        nchk++;
        if (cycle_cnt !== 64'd0) begin
            nerr++;
            $display("FAIL reset_cycle_cnt got=%0d want=0", cycle_cnt);
        end
        nchk++;
        if (finish_code !== 8'h00) begin
            nerr++;
            $display("FAIL reset_finish_code got=%h want=00", finish_code);
        end
    endtask

    task automatic test_bringup();
        run_case(30, 0, 8'h00, 3, 20, 60, 0, 30);
        nchk++;
        if (fall_t !== RC) begin
            nerr++;
            $display("FAIL bringup_reset_fall got=%0d want=%0d", fall_t, RC);
        end
        nchk++;
        if (init_t !== RC) begin
            nerr++;
            $display("FAIL bringup_init_req got=%0d want=%0d", init_t, RC);
        end
        nchk++;
        if (first_t !== RC + 4) begin
            nerr++;
            $display("FAIL bringup_first_step got=%0d want=%0d",
                     first_t, RC + 4);
        end
        nchk++;
        if (first_cnt !== 64'd0) begin
            nerr++;
            $display("FAIL bringup_first_cnt got=%0d want=0", first_cnt);
        end
    endtask

    task automatic test_timeout();
        run_case(100, 0, 8'h00, 1, 0, 100, 0, 100);
        nchk++;
        if (nsteps !== 100 || fin_ok !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_steps got=%0d fin=%0b want=100 fin=1",
                     nsteps, fin_ok);
        end
        nchk++;
        if (finish_code !== 8'hFF || cycle_cnt !== 64'd100) begin
            nerr++;
            $display("FAIL timeout_code got=%h/%0d want=ff/100",
                     finish_code, cycle_cnt);
        end
    endtask

    task automatic test_tie();
        run_case(20, 20, 8'h03, 2, 10, 80, 0, 20);
        nchk++;
        if (finish_code !== 8'h03 || nsteps !== 20 || fin_ok !== 1'b1) begin
            nerr++;
            $display("FAIL tie_code got=%h steps=%0d want=03 steps=20",
                     finish_code, nsteps);
        end
    endtask

    task automatic test_hold_finish();
        int bad;
        bad = 0;
        bring_up(2);
        uart_out_ready = 1'b0;
        uart_in_valid = 1'b1;
        uart_in_ch = 8'h48;
        step();
        uart_in_ch = 8'h69;
        step();
        uart_in_valid = 1'b0;
        step_rsp_valid = 1'b1;
        step_rsp_code = 8'h01;
        step();
        step_rsp_valid = 1'b0;
        step_rsp_code = 8'h00;
        repeat (10) begin
            if (finish !== 1'b0) bad++;
            step();
        end
        nchk++;
        if (bad !== 0) begin
            nerr++;
            $display("FAIL hold_finish_early got=%0d want=0", bad);
        end
        uart_out_ready = 1'b1;
        for (int n = 0; n < 20 && finish !== 1'b1; n++) step();
        nchk++;
        if (got_q.size() !== 2 || finish !== 1'b1) begin
            nerr++;
            $display("FAIL hold_finish_drain got=%0d fin=%b want=2 fin=1",
                     got_q.size(), finish);
        end else begin
            nchk++;
            if (got_q[0] !== 8'h48 || got_q[1] !== 8'h69) begin
                nerr++;
                $display("FAIL hold_finish_order got=%h%h want=4869",
                         got_q[0], got_q[1]);
            end
        end
        nchk++;
        if (finish_code !== 8'h01) begin
            nerr++;
            $display("FAIL hold_finish_code got=%h want=01", finish_code);
        end
    endtask

    task automatic test_overflow();
        int bad;
        bad = 0;
        bring_up(1);
        uart_out_ready = 1'b0;
        uart_in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            uart_in_ch = 8'($urandom);
            step();
        end
        nchk++;
        if (uart_overflow !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_fill got=%b want=0", uart_overflow);
        end
        uart_out_ready = 1'b1;
        uart_in_ch = 8'($urandom);
        step();
        uart_out_ready = 1'b0;
        nchk++;
        if (uart_overflow !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_push_pop got=%b want=0", uart_overflow);
        end
        uart_in_ch = 8'($urandom);
        step();
        uart_in_valid = 1'b0;
        nchk++;
        if (uart_overflow !== exp_ovf || exp_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_drop got=%b want=1", uart_overflow);
        end
        uart_out_ready = 1'b1;
        repeat (DEPTH + 2) step();
        nchk++;
        if (got_q.size() !== exp_q.size() || got_q.size() !== DEPTH + 1) begin
            nerr++;
            $display("FAIL ovf_count got=%0d want=%0d",
                     got_q.size(), DEPTH + 1);
        end else begin
            foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
            nchk++;
            if (bad !== 0) begin
                nerr++;
                $display("FAIL ovf_data got=%0d bad want=0", bad);
            end
        end
        nchk++;
        if (vbad !== 0 || hbad !== 0) begin
            nerr++;
            $display("FAIL ovf_head got=%0d/%0d want=0/0", vbad, hbad);
        end
    endtask

    task automatic test_reset_midrun();
        bring_up(1);
        uart_out_ready = 1'b0;
        uart_in_valid = 1'b1;
        repeat (5) begin
            uart_in_ch = 8'($urandom);
            step();
        end
        uart_in_valid = 1'b0;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        nchk++;
        if ({dut_reset, init_req, step_req, uart_out_valid, uart_overflow,
             finish} !== 6'b100000 || cycle_cnt !== 64'd0 ||
            finish_code !== 8'h00) begin
            nerr++;
            $display("FAIL midrun_reset got=%b cnt=%0d code=%h want=100000",
                     {dut_reset, init_req, step_req, uart_out_valid,
                      uart_overflow, finish}, cycle_cnt, finish_code);
        end
        @(negedge clock);
        reset = 1'b1;
        clear_model();
        step();
        nchk++;
        if (uart_out_valid !== 1'b0 || dut_reset !== 1'b1) begin
            nerr++;
            $display("FAIL midrun_release got=%b%b want=01",
                     uart_out_valid, dut_reset);
        end
    endtask

    task automatic test_random();
        int m;
        int s;
        int e;
        int bad;
        logic [7:0] sc;
        logic [7:0] ec;
        for (int it = 0; it < 6; it++) begin
            m = $urandom_range(1, 80);
            s = $urandom_range(0, 90);
            sc = 8'($urandom_range(1, 255));
            if (s != 0 && s <= m) begin
                e = s;
                ec = sc;
            end else begin
                e = m;
                ec = 8'hFF;
            end
            run_case(m, s, sc, $urandom_range(0, 6), 35, 50,
                     $urandom_range(0, 10), e);
            nchk++;
            if (fin_ok !== 1'b1 || nsteps !== e || cycle_cnt !== 64'(e)) begin
                nerr++;
                $display("FAIL rand%0d_len fin=%b got=%0d/%0d want=%0d",
                         it, fin_ok, nsteps, cycle_cnt, e);
            end
            nchk++;
            if (finish_code !== ec) begin
                nerr++;
                $display("FAIL rand%0d_code got=%h want=%h",
                         it, finish_code, ec);
            end
            nchk++;
            if (uart_overflow !== exp_ovf) begin
                nerr++;
                $display("FAIL rand%0d_ovf got=%b want=%b",
                         it, uart_overflow, exp_ovf);
            end
            bad = vbad + hbad;
            foreach (got_q[i])
                if (i >= exp_q.size() || got_q[i] !== exp_q[i]) bad++;
            nchk++;
            if (bad !== 0) begin
                nerr++;
                $display("FAIL rand%0d_uart got=%0d bad want=0", it, bad);
            end
            repeat (4) step();
            nchk++;
            if (finish !== 1'b1 || dut_reset !== 1'b0 ||
                finish_code !== ec) begin
                nerr++;
                $display("FAIL rand%0d_held got=%b%b/%h want=10/%h",
                         it, finish, dut_reset, finish_code, ec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_tie();
        test_hold_finish();
        test_overflow();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
